uart_tx_sched: RTL and testbench

UART_TX_SCHED -- requirements
Module: uart_tx_sched

---
 rtl/uart_tx_sched.sv | 96 +++++++++
 tb/tb_uart_tx_sched.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_sched.sv
// Round-robin scheduler feeding NREQ word requesters to one UART transmitter, LSB byte first.
// Grant/tx_start one cycle after req; each next byte one cycle after tx_done_tick; req held until ack.
module uart_tx_sched #(
  parameter int NREQ       = 4,
  parameter int WORD_BYTES = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NREQ-1:0]      req,
  input  logic [32*NREQ-1:0]   word,
  output logic [NREQ-1:0]      ack,
  output logic [NREQ-1:0]      done,
  output logic                 tx_start,
  output logic [7:0]           din,
  input  logic                 tx_done_tick,
  output logic                 busy
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [1:0] LAST = 2'(WORD_BYTES - 1);
  localparam logic [NREQ-1:0] ONE = NREQ'(1);

  typedef enum logic [1:0] {IDLE, SEND, WAIT, DONE} state_t;

  state_t        state;
  logic [PW-1:0] ptr;
  logic [PW-1:0] owner;
  logic [PW-1:0] win;
  logic [PW-1:0] cand;
  logic [1:0]    cnt;
  logic [31:0]   data;

  // Walk offsets from the far end so the requester closest to ptr is written last and wins.
  always_comb begin
    win  = ptr;
    cand = ptr;
    for (int j = NREQ - 1; j >= 0; j--) begin
      cand = PW'((int'(ptr) + j) % NREQ);
      if (req[cand]) win = cand;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      ptr      <= '0;
      owner    <= '0;
      cnt      <= '0;
      data     <= '0;
      ack      <= '0;
      done     <= '0;
      tx_start <= 1'b0;
      din      <= '0;
      busy     <= 1'b0;
    end else begin
      ack      <= '0;
      done     <= '0;
      tx_start <= 1'b0;
      case (state)
        IDLE: begin
          if (|req) begin
            owner    <= win;
            ptr      <= (win == PW'(NREQ - 1)) ? '0 : win + PW'(1);
            data     <= word[{win, 5'b0} +: 32];
            cnt      <= '0;
            ack      <= ONE << win;
            tx_start <= 1'b1;
            din      <= word[{win, 5'b0} +: 8];
            busy     <= 1'b1;
            state    <= SEND;
          end
        end
        SEND: state <= WAIT;
        WAIT: begin
          if (tx_done_tick) begin
            if (cnt == LAST) begin
              done  <= ONE << owner;
              state <= DONE;
            end else begin
              cnt      <= cnt + 2'd1;
              din      <= data[{cnt + 2'd1, 3'b0} +: 8];
              tx_start <= 1'b1;
              state    <= SEND;
            end
          end
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_sched.sv
// Directed bench for uart_tx_sched: a transmitter model answers each tx_start with a tick.
module tb_uart_tx_sched;
  localparam int NREQ = 4;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic [NREQ-1:0]   req = '0;
  logic [32*NREQ-1:0] word = '0;
  logic [NREQ-1:0]   ack;
  logic [NREQ-1:0]   done;
  logic              tx_start;
  logic [7:0]        din;
  logic              tx_done_tick = 1'b0;
  logic              busy;

  int n_checks = 0;
  int n_fail   = 0;

  uart_tx_sched #(.NREQ(NREQ), .WORD_BYTES(4)) dut (
    .clk(clk), .reset(reset), .req(req), .word(word), .ack(ack), .done(done),
    .tx_start(tx_start), .din(din), .tx_done_tick(tx_done_tick), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Transmitter model: starting in a SEND cycle, ticks 'gap' cycles after every tx_start until done.
  task automatic collect(input int gap, output logic [31:0] bytes, output int n_start,
                         output int n_ack, output logic [NREQ-1:0] done_v, output int n_done);
    int cd;
    bytes = '0; n_start = 0; n_ack = 0; done_v = '0; n_done = 0; cd = 0;
    if (tx_start) begin bytes[7:0] = din; n_start = 1; cd = gap; end
    for (int c = 0; c < 200 && n_done == 0; c++) begin
      tx_done_tick = (cd == 1);
      if (cd > 0) cd--;
      step();
      tx_done_tick = 1'b0;
      if (tx_start) begin
        if (n_start < 4) bytes[8*n_start +: 8] = din;
        n_start++;
        cd = gap;
      end
      if (ack != 0) n_ack++;
      if (done != 0) begin done_v = done; n_done++; end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; req = '0; word = '0; tx_done_tick = 1'b0;
    step(); step();
    n_checks++; if (ack !== 4'b0000) begin n_fail++; $display("FAIL reset_ack got %b want 0000", ack); end
    n_checks++; if (done !== 4'b0000) begin n_fail++; $display("FAIL reset_done got %b want 0000", done); end
    n_checks++; if (tx_start !== 1'b0) begin n_fail++; $display("FAIL reset_tx_start got %b want 0", tx_start); end
    n_checks++; if (din !== 8'h00) begin n_fail++; $display("FAIL reset_din got %h want 00", din); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
    reset = 1'b0;
    step();
  endtask

  task automatic test_single();
    logic [31:0] exp;
    int stray;
    exp = 32'hA1B2C3D4;
    word[31:0] = exp; req = 4'b0001;
    step();
    n_checks++; if (ack !== 4'b0001) begin n_fail++; $display("FAIL single_ack got %b want 0001", ack); end
    n_checks++; if (tx_start !== 1'b1) begin n_fail++; $display("FAIL single_start got %b want 1", tx_start); end
    n_checks++; if (din !== 8'hD4) begin n_fail++; $display("FAIL single_din0 got %h want d4", din); end
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL single_busy got %b want 1", busy); end
    req = '0;
    for (int b = 0; b < 4; b++) begin
      stray = 0;
      for (int c = 0; c < 19; c++) begin
        step();
        if (tx_start || ack != 0 || done != 0) stray++;
      end
      n_checks++; if (stray !== 0) begin n_fail++; $display("FAIL single_wait%0d stray pulses got %0d want 0", b, stray); end
      n_checks++; if (din !== exp[8*b +: 8]) begin n_fail++; $display("FAIL single_hold%0d got %h want %h", b, din, exp[8*b +: 8]); end
      tx_done_tick = 1'b1; step(); tx_done_tick = 1'b0;
      if (b < 3) begin
        n_checks++; if (tx_start !== 1'b1 || din !== exp[8*(b+1) +: 8]) begin
          n_fail++; $display("FAIL single_byte%0d got start=%b din=%h want start=1 din=%h", b + 1, tx_start, din, exp[8*(b+1) +: 8]);
        end
      end else begin
        n_checks++; if (done !== 4'b0001 || tx_start !== 1'b0) begin
          n_fail++; $display("FAIL single_done got done=%b start=%b want done=0001 start=0", done, tx_start);
        end
      end
    end
    step();
    n_checks++; if (done !== 4'b0000 || busy !== 1'b0) begin
      n_fail++; $display("FAIL single_after got done=%b busy=%b want 0000/0", done, busy);
    end
  endtask

  task automatic test_round_robin();
    logic [31:0] bytes; logic [NREQ-1:0] dv; int ns, na, nd, exp;
    logic [NREQ-1:0] oh;
    reset = 1'b1; step(); reset = 1'b0;
    word = {32'hD3D2D1D0, 32'hC3C2C1C0, 32'hB3B2B1B0, 32'hA3A2A1A0};
    req = 4'b1111;
    for (int t = 0; t < 5; t++) begin
      exp = t % 4;
      oh = 4'b0001 << exp;
      if (t > 0) begin
        step();
        n_checks++; if (tx_start !== 1'b0 || busy !== 1'b0) begin
          n_fail++; $display("FAIL rr_gap%0d got start=%b busy=%b want 0/0", t, tx_start, busy);
        end
      end
      step();
      n_checks++; if (ack !== oh) begin n_fail++; $display("FAIL rr_ack%0d got %b want %b", t, ack, oh); end
      collect(3, bytes, ns, na, dv, nd);
      n_checks++; if (bytes !== word[32*exp +: 32] || ns !== 4) begin
        n_fail++; $display("FAIL rr_bytes%0d got %h/%0d want %h/4", t, bytes, ns, word[32*exp +: 32]);
      end
      n_checks++; if (na !== 0 || dv !== oh) begin
        n_fail++; $display("FAIL rr_done%0d got extra_acks=%0d done=%b want 0/%b", t, na, dv, oh);
      end
    end
    req = '0;
    step();
  endtask

  task automatic test_pointer_skip();
    logic [31:0] bytes; logic [NREQ-1:0] dv; int ns, na, nd;
    reset = 1'b1; step(); reset = 1'b0;
    req = 4'b0010;
    step();
    n_checks++; if (ack !== 4'b0010) begin n_fail++; $display("FAIL skip_ack1 got %b want 0010", ack); end
    req = 4'b0101;
    collect(2, bytes, ns, na, dv, nd);
    n_checks++; if (dv !== 4'b0010) begin n_fail++; $display("FAIL skip_done1 got %b want 0010", dv); end
    step(); step();
    n_checks++; if (ack !== 4'b0100) begin n_fail++; $display("FAIL skip_ack2 got %b want 0100", ack); end
    req = 4'b0001;
    collect(2, bytes, ns, na, dv, nd);
    step(); step();
    n_checks++; if (ack !== 4'b0001) begin n_fail++; $display("FAIL skip_ack0 got %b want 0001", ack); end
    req = '0;
    collect(2, bytes, ns, na, dv, nd);
    n_checks++; if (dv !== 4'b0001) begin n_fail++; $display("FAIL skip_done0 got %b want 0001", dv); end
    step();
  endtask

  task automatic test_payload_stable();
    logic [31:0] bytes; logic [NREQ-1:0] dv; int ns, na, nd;
    word[31:0] = 32'h12345678; req = 4'b0001;
    step();
    n_checks++; if (ack !== 4'b0001) begin n_fail++; $display("FAIL stable_ack got %b want 0001", ack); end
    req = '0; word[31:0] = 32'hFFFFFFFF;
    collect(4, bytes, ns, na, dv, nd);
    n_checks++; if (bytes !== 32'h12345678 || ns !== 4) begin
      n_fail++; $display("FAIL stable_bytes got %h/%0d want 12345678/4", bytes, ns);
    end
    n_checks++; if (dv !== 4'b0001) begin n_fail++; $display("FAIL stable_done got %b want 0001", dv); end
    step();
  endtask

  task automatic test_stray_ticks();
    logic [31:0] bytes; logic [NREQ-1:0] dv; int ns, na, nd, stray;
    tx_done_tick = 1'b1; step(); tx_done_tick = 1'b0;
    n_checks++; if (busy !== 1'b0 || tx_start !== 1'b0) begin
      n_fail++; $display("FAIL stray_idle got busy=%b start=%b want 0/0", busy, tx_start);
    end
    word[31:0] = 32'hCAFEF00D; req = 4'b0001;
    step();
    n_checks++; if (tx_start !== 1'b1 || din !== 8'h0D) begin
      n_fail++; $display("FAIL stray_first got start=%b din=%h want 1/0d", tx_start, din);
    end
    req = '0;
    tx_done_tick = 1'b1; step(); tx_done_tick = 1'b0;
    stray = 0;
    for (int c = 0; c < 3; c++) begin
      if (tx_start) stray++;
      step();
    end
    if (tx_start) stray++;
    n_checks++; if (stray !== 0 || din !== 8'h0D || busy !== 1'b1) begin
      n_fail++; $display("FAIL stray_send got starts=%0d din=%h busy=%b want 0/0d/1", stray, din, busy);
    end
    tx_done_tick = 1'b1; step(); tx_done_tick = 1'b0;
    n_checks++; if (tx_start !== 1'b1 || din !== 8'hF0) begin
      n_fail++; $display("FAIL stray_wait_tick got start=%b din=%h want 1/f0", tx_start, din);
    end
    collect(3, bytes, ns, na, dv, nd);
    n_checks++; if (bytes !== 32'h00CAFEF0 || ns !== 3 || dv !== 4'b0001) begin
      n_fail++; $display("FAIL stray_rest got %h/%0d/%b want 00cafef0/3/0001", bytes, ns, dv);
    end
    tx_done_tick = 1'b1; step(); tx_done_tick = 1'b0;
    step();
    n_checks++; if (busy !== 1'b0 || tx_start !== 1'b0) begin
      n_fail++; $display("FAIL stray_done_tick got busy=%b start=%b want 0/0", busy, tx_start);
    end
  endtask

  task automatic test_reset_mid_wait();
    logic [31:0] bytes; logic [NREQ-1:0] dv; int ns, na, nd, seen;
    word[95:64] = 32'h89ABCDEF; req = 4'b0100;
    step();
    n_checks++; if (ack !== 4'b0100) begin n_fail++; $display("FAIL rst_ack2 got %b want 0100", ack); end
    req = '0;
    step();
    tx_done_tick = 1'b1; step(); tx_done_tick = 1'b0;
    step();
    tx_done_tick = 1'b1; step(); tx_done_tick = 1'b0;
    step();
    n_checks++; if (din !== 8'hAB || tx_start !== 1'b0 || busy !== 1'b1) begin
      n_fail++; $display("FAIL rst_wait2 got din=%h start=%b busy=%b want ab/0/1", din, tx_start, busy);
    end
    reset = 1'b1; step(); reset = 1'b0;
    n_checks++; if (ack !== 4'b0 || done !== 4'b0 || tx_start !== 1'b0 || din !== 8'h00 || busy !== 1'b0) begin
      n_fail++; $display("FAIL rst_outputs got ack=%b done=%b start=%b din=%h busy=%b want all 0", ack, done, tx_start, din, busy);
    end
    seen = 0;
    for (int c = 0; c < 6; c++) begin
      tx_done_tick = (c == 1);
      step();
      if (done != 0 || tx_start || busy) seen++;
    end
    tx_done_tick = 1'b0;
    n_checks++; if (seen !== 0) begin n_fail++; $display("FAIL rst_no_done got %0d active cycles want 0", seen); end
    // Requester 3 also asks: a pointer left at 3 by the aborted grant would pick it over 1.
    req = 4'b1010;
    step();
    n_checks++; if (ack !== 4'b0010) begin n_fail++; $display("FAIL rst_regrant got %b want 0010", ack); end
    req = '0;
    collect(2, bytes, ns, na, dv, nd);
    n_checks++; if (dv !== 4'b0010) begin n_fail++; $display("FAIL rst_final_done got %b want 0010", dv); end
    step();
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_pointer_skip();
    test_payload_stable();
    test_stray_ticks();
    test_reset_mid_wait();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
